// File: rtl/plic.sv
// plic: platform-level interrupt controller with per-source gateways,
// priority/threshold arbitration, and claim/complete over a simple req/ack bus.
module plic #(
    parameter int NSRC   = 8,
    parameter int PRIO_W = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            bus_req,
    input  logic            bus_we,
    input  logic [11:0]     bus_addr,
    input  logic [31:0]     bus_wdata,
    output logic [31:0]     bus_rdata,
    output logic            bus_ack,
    input  logic [NSRC-1:0] src,
    output logic            irq_ext
);
    logic [NSRC:1]     s1, s2, s3, req, infl;
    logic [NSRC:0]     pend, trig, en;
    logic [PRIO_W-1:0] prio [1:NSRC];
    logic [PRIO_W-1:0] thr, best;
    logic [4:0]        win;
    logic [9:0]        word;
    logic [31:0]       rd;
    logic              wr, claim, complete, unused_bits;

    // The master holds address/data until ack, so the ack cycle acts on the live bus inputs.
    assign word        = bus_addr[11:2];
    assign wr          = bus_ack & bus_we;
    assign claim       = bus_ack & ~bus_we & (word == 10'h081);
    assign complete    = wr & (word == 10'h081);
    assign req         = (trig[NSRC:1] & s2 & ~s3) | (~trig[NSRC:1] & s2);
    assign bus_rdata   = bus_ack ? rd : '0;
    assign unused_bits = ^{bus_addr[1:0], bus_wdata};

    // Ascending scan with a strict compare keeps the lowest ID on priority ties.
    always_comb begin
        win  = '0;
        best = '0;
        for (int n = 1; n <= NSRC; n++)
            if (pend[n] && en[n] && prio[n] > thr && prio[n] > best) begin
                win  = 5'(n);
                best = prio[n];
            end
    end

    always_comb begin
        rd = word == 10'h020 ? 32'(pend) :
             word == 10'h030 ? 32'(trig) :
             word == 10'h040 ? 32'(en)   :
             word == 10'h080 ? 32'(thr)  :
             word == 10'h081 ? 32'(win)  : 32'd0;
        for (int n = 1; n <= NSRC; n++)
            if (word == 10'(n)) rd = 32'(prio[n]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_ack <= 1'b0;
            irq_ext <= 1'b0;
            s1      <= '0;
            s2      <= '0;
            s3      <= '0;
            pend    <= '0;
            infl    <= '0;
            trig    <= '0;
            en      <= '0;
            thr     <= '0;
            for (int n = 1; n <= NSRC; n++) prio[n] <= '0;
        end else begin
            bus_ack <= bus_req & ~bus_ack;
            irq_ext <= win != 5'd0;
            s1      <= src;
            s2      <= s1;
            s3      <= s2;
            if (wr && word == 10'h030) trig <= {bus_wdata[NSRC:1], 1'b0};
            if (wr && word == 10'h040) en <= {bus_wdata[NSRC:1], 1'b0};
            if (wr && word == 10'h080) thr <= bus_wdata[PRIO_W-1:0];
            for (int n = 1; n <= NSRC; n++) begin
                if (wr && word == 10'(n)) prio[n] <= bus_wdata[PRIO_W-1:0];
                if (claim && win == 5'(n)) begin
                    pend[n] <= 1'b0;
                    infl[n] <= 1'b1;
                end else if (req[n] && !pend[n] && !infl[n]) begin
                    pend[n] <= 1'b1;
                end
                if (complete && bus_wdata[4:0] == 5'(n)) infl[n] <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_plic.sv
// tb_plic: directed checks of the PLIC register map, gateways, arbitration,
// claim/complete and reset behaviour.
module tb_plic;
    logic        clk = 1'b0, rst = 1'b1, bus_req = 1'b0, bus_we = 1'b0;
    logic [11:0] bus_addr = '0;
    logic [31:0] bus_wdata = '0, bus_rdata, r;
    logic        bus_ack, irq_ext;
    logic [7:0]  src = 8'hFF;
    int          passed = 0, total = 0;

    always #5 clk = ~clk;

    plic #(.NSRC(8), .PRIO_W(3)) dut (
        .clk(clk), .rst(rst), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .bus_ack(bus_ack), .src(src), .irq_ext(irq_ext)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic access(input logic we, input logic [11:0] a, input logic [31:0] d,
                          output logic [31:0] q);
        bus_req   = 1'b1;
        bus_we    = we;
        bus_addr  = a;
        bus_wdata = d;
        tick;
        chk("ack", 32'(bus_ack), 32'd1);
        q = bus_rdata;
        tick;
        bus_req = 1'b0;
        bus_we  = 1'b0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        logic [31:0] q;
        access(1'b1, a, d, q);
    endtask

    task automatic rdchk(input string tag, input logic [11:0] a, input logic [31:0] exp);
        logic [31:0] q;
        access(1'b0, a, 32'd0, q);
        chk(tag, q, exp);
    endtask

    task automatic pulse(input logic [7:0] m);
        src = src | m;
        tick;
        src = src & ~m;
        repeat (3) tick;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        repeat (2) tick;
        rst = 1'b0;
        tick;
    endtask

    initial begin
        // reset with every source high
        tick;
        chk("rst_irq", 32'(irq_ext), 32'd0);
        chk("rst_ack", 32'(bus_ack), 32'd0);
        chk("rst_rdata", bus_rdata, 32'd0);
        rst = 1'b0;
        repeat (5) tick;
        chk("prio0_irq", 32'(irq_ext), 32'd0);
        rdchk("rst_prio0", 12'h000, 32'd0);
        rdchk("rst_prio1", 12'h004, 32'd0);
        rdchk("rst_prio8", 12'h020, 32'd0);
        rdchk("rst_trig", 12'h0C0, 32'd0);
        rdchk("rst_en", 12'h100, 32'd0);
        rdchk("rst_thr", 12'h200, 32'd0);
        rdchk("rst_claim", 12'h204, 32'd0);
        chk("prio0_irq2", 32'(irq_ext), 32'd0);
        src = 8'h00;
        do_reset;

        // edge source ID 3
        wr(12'h00C, 32'd2);
        wr(12'h100, 32'h08);
        wr(12'h200, 32'd0);
        wr(12'h0C0, 32'h08);
        rdchk("prio3_rb", 12'h00C, 32'd2);
        rdchk("trig_rb", 12'h0C0, 32'h08);
        src = 8'h04;
        @(posedge clk);
        @(negedge clk);
        src = 8'h00;
        chk("irq_k", 32'(irq_ext), 32'd0);
        tick;
        chk("irq_k1", 32'(irq_ext), 32'd0);
        tick;
        chk("irq_k2", 32'(irq_ext), 32'd0);
        tick;
        chk("irq_k3", 32'(irq_ext), 32'd1);
        rdchk("pend3", 12'h080, 32'h08);
        access(1'b0, 12'h204, 32'd0, r);
        chk("claim3", r, 32'd3);
        chk("irq_after_claim", 32'(irq_ext), 32'd1);
        tick;
        chk("irq_drop", 32'(irq_ext), 32'd0);
        rdchk("pend3_clr", 12'h080, 32'd0);
        pulse(8'h04);
        rdchk("pend3_inflight", 12'h080, 32'd0);
        wr(12'h204, 32'd3);
        pulse(8'h04);
        rdchk("pend3_again", 12'h080, 32'h08);
        rdchk("claim3b", 12'h204, 32'd3);
        wr(12'h204, 32'd3);

        // priority, threshold and tie-break
        do_reset;
        wr(12'h008, 32'd4);
        wr(12'h014, 32'd4);
        wr(12'h01C, 32'd6);
        wr(12'h0C0, 32'hA4);
        wr(12'h100, 32'hA4);
        wr(12'h200, 32'd5);
        pulse(8'h52);
        rdchk("pend_257", 12'h080, 32'hA4);
        wr(12'h080, 32'hFF);
        rdchk("pend_ro", 12'h080, 32'hA4);
        rdchk("claim7", 12'h204, 32'd7);
        rdchk("claim_masked", 12'h204, 32'd0);
        chk("irq_masked", 32'(irq_ext), 32'd0);
        wr(12'h200, 32'd3);
        rdchk("claim2", 12'h204, 32'd2);
        rdchk("claim5", 12'h204, 32'd5);
        rdchk("claim_none", 12'h204, 32'd0);
        chk("irq_none", 32'(irq_ext), 32'd0);
        wr(12'h204, 32'd2);
        wr(12'h204, 32'd5);
        wr(12'h204, 32'd7);

        // level source ID 1
        do_reset;
        wr(12'h004, 32'd1);
        wr(12'h100, 32'h02);
        src = 8'h01;
        repeat (4) tick;
        rdchk("pend1", 12'h080, 32'h02);
        chk("irq_lvl", 32'(irq_ext), 32'd1);
        wr(12'h100, 32'd0);
        tick;
        chk("irq_en_off", 32'(irq_ext), 32'd0);
        rdchk("pend1_kept", 12'h080, 32'h02);
        wr(12'h100, 32'h02);
        rdchk("claim1", 12'h204, 32'd1);
        rdchk("pend1_inflight", 12'h080, 32'd0);
        wr(12'h204, 32'd9);
        wr(12'h204, 32'd2);
        repeat (3) tick;
        rdchk("pend1_bad_complete", 12'h080, 32'd0);
        wr(12'h204, 32'd1);
        chk("irq_cmp_e0", 32'(irq_ext), 32'd0);
        tick;
        chk("irq_cmp_e1", 32'(irq_ext), 32'd0);
        tick;
        chk("irq_cmp_e2", 32'(irq_ext), 32'd1);
        rdchk("pend1_again", 12'h080, 32'h02);
        src = 8'h00;
        rdchk("claim1b", 12'h204, 32'd1);
        wr(12'h204, 32'd1);

        // edge source ID 4: dropped edges and claim racing an edge
        do_reset;
        wr(12'h010, 32'd1);
        wr(12'h0C0, 32'h10);
        wr(12'h100, 32'h10);
        pulse(8'h08);
        rdchk("pend4", 12'h080, 32'h10);
        rdchk("claim4", 12'h204, 32'd4);
        pulse(8'h08);
        pulse(8'h08);
        rdchk("pend4_inflight", 12'h080, 32'd0);
        wr(12'h204, 32'd4);
        rdchk("pend4_dropped", 12'h080, 32'd0);
        pulse(8'h08);
        rdchk("pend4_new", 12'h080, 32'h10);
        src = 8'h08;
        tick;
        src = 8'h00;
        access(1'b0, 12'h204, 32'd0, r);
        chk("claim4_race", r, 32'd4);
        repeat (3) tick;
        rdchk("pend4_race", 12'h080, 32'd0);
        chk("irq_race", 32'(irq_ext), 32'd0);
        wr(12'h204, 32'd4);

        // reset during the ack cycle of an enable write
        bus_req   = 1'b1;
        bus_we    = 1'b1;
        bus_addr  = 12'h100;
        bus_wdata = 32'hFF;
        @(posedge clk);
        #1;
        chk("mid_ack", 32'(bus_ack), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_ack", 32'(bus_ack), 32'd0);
        chk("mid_rst_rdata", bus_rdata, 32'd0);
        bus_req = 1'b0;
        bus_we  = 1'b0;
        tick;
        rst = 1'b0;
        tick;
        chk("post_rst_ack0", 32'(bus_ack), 32'd0);
        tick;
        chk("post_rst_ack1", 32'(bus_ack), 32'd0);
        rdchk("en_lost", 12'h100, 32'd0);
        rdchk("hole_rd", 12'h300, 32'd0);
        wr(12'h300, 32'hFFFF_FFFF);
        rdchk("hole_rd2", 12'h300, 32'd0);
        chk("final_irq", 32'(irq_ext), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
